// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the shared-UART transmit scheduler.
package tx_sched_pkg;

    localparam int unsigned CLKS_PER_BIT      = 5208;
    localparam int unsigned FRAME_BITS        = 11;
    localparam int unsigned BYTE_W            = 8;

    localparam int unsigned DEF_NUM_REQ       = 4;
    localparam int unsigned DEF_FIFO_DEPTH    = 4;
    localparam int unsigned DEF_START_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } tx_sched_state_t;

    // Index visited at step 'off' of a round-robin search that begins after 'last'.
    function automatic int unsigned rr_index(input int unsigned last,
                                             input int unsigned off,
                                             input int unsigned n);
        return (last + 1 + off) % n;
    endfunction

endpackage

// File: rtl/tx_req_fifo.sv
// Per-requester byte FIFO; full/empty come straight from the registered count.
module tx_req_fifo
    import tx_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_c, pop_c;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    // Accept/pop qualification, pointer wrap and occupancy update.
    always_comb begin
        push_c     = wr_en && !full;
        pop_c      = rd_en && !empty;
        wr_ptr_d   = push_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_c  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        overflow_d = wr_en && full;
    end

    // Pointer, count and overflow-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler feeding a single tx_core from NUM_REQ byte FIFOs.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          wr_en,
    input  logic [NUM_REQ*BYTE_W-1:0]   wr_data,
    output logic [NUM_REQ-1:0]          full,
    output logic [NUM_REQ-1:0]          overflow,
    output logic                        send_data,
    output logic [BYTE_W-1:0]           data_tx,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        start_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned TW  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    tx_sched_state_t   state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              send_q, send_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    last_q, last_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] empty_c;
    logic [NUM_REQ-1:0] rd_en_c;
    logic [BYTE_W-1:0]  fifo_rd_data [NUM_REQ];
    logic [IDW-1:0]     cand_c;
    logic [IDW-1:0]     win_c;
    logic               any_c;

    // One FIFO per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        tx_req_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[g]),
            .wr_data  (wr_data[g*BYTE_W +: BYTE_W]),
            .rd_en    (rd_en_c[g]),
            .rd_data  (fifo_rd_data[g]),
            .empty    (empty_c[g]),
            .full     (full[g]),
            .overflow (overflow[g])
        );
    end

    // Round-robin search: first non-empty FIFO after the last granted one.
    always_comb begin
        cand_c = '0;
        win_c  = '0;
        any_c  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = IDW'(rr_index(32'(last_q), k, NUM_REQ));
            if (!any_c && !empty_c[cand_c]) begin
                any_c = 1'b1;
                win_c = cand_c;
            end
        end
    end

    // Next-state and registered-output logic for the transmit handshake.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        send_d  = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        err_d   = 1'b0;
        rd_en_c = '0;
        unique case (state_q)
            IDLE: begin
                if (any_c) begin
                    rd_en_c[win_c] = 1'b1;
                    data_d         = fifo_rd_data[win_c];
                    grant_d        = win_c;
                    last_d         = win_c;
                    tmo_d          = '0;
                    send_d         = 1'b1;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    state_d = DRAIN;
                end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                    // Core never answered: report and drop the byte.
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    tmo_d  = tmo_q + TW'(1);
                    send_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops send_data immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            send_q  <= send_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign send_data = send_q;
    assign data_tx   = data_q;
    assign grant_id  = grant_q;
    assign start_err = err_q;

endmodule
